icache_nway: RTL and testbench
==============================

Name: icache_nway

Overview:
- Parametrised set-associative instruction cache. Successor to the fixed 4KB direct-mapped icache.
- Sits between the CPU fetch stage and the AXI read fabric.
- Generalises way count, set count and line length.
- Adds invalid-first/round-robin victim selection, a read-side refill error per line, and per-way hit/miss counters.

Parameters:
- AXI_ID, 4, value driven on axi_arid_o.
- NUM_WAYS, 2, associativity; power of two, 1..8.
- NUM_SETS, 64, lines per way; power of two, 16..1024.
- LINE_WORDS, 8, 32-bit words per line; power of two, 2..16.
- Derived: OFS_W=log2(LINE_WORDS)+2, SET_W=log2(NUM_SETS), TAG_W=32-SET_W-OFS_W.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_rd_i  in  1  fetch request
- req_flush_i  in  1  invalidate whole cache
- req_invalidate_i  in  1  invalidate set addressed by req_pc_i, all ways
- req_pc_i  in  32  fetch address (bits [1:0] ignored)
- req_accept_o  out  1  request/flush/invalidate accepted this cycle
- req_valid_o  out  1  instruction valid
- req_error_o  out  1  instruction came from a line whose refill returned non-OKAY
- req_inst_o  out  32  instruction word
- axi_arvalid_o  out  1  read address valid
- axi_araddr_o  out  32  line-aligned address
- axi_arid_o  out  4  AXI_ID
- axi_arlen_o  out  8  LINE_WORDS-1
- axi_arburst_o  out  2  2'd1 (INCR)
- axi_arsize_o  out  3  3'd2
- axi_arready_i  in  1  address accepted
- axi_rvalid_i  in  1  read data valid
- axi_rdata_i  in  32  read data
- axi_rresp_i  in  2  response
- axi_rlast_i  in  1  last beat
- axi_rready_o  out  1  constant 1
- stat_hit_o  out  32  hit counter, saturating
- stat_miss_o  out  32  miss counter, saturating

Behaviour:
- Reset (async assert, sync deassert):
  - state=FLUSH, flush pointer=0, victim pointer=0.
  - All outputs 0 except axi_rready_o=1 and the constant AXI fields.
- States:
  - FLUSH: write the all-zero tag (valid=0) to every way at the flush pointer, one set per cycle. Leave after set NUM_SETS-1, or after one cycle if entered via invalidate, then go to LOOKUP.
  - LOOKUP: tag and data RAMs are synchronous read, addressed by req_pc_i in the accept cycle.
    - Next cycle compare all ways against the registered pc tag.
    - Hit: req_valid_o=1 with the hitting way's word (1-cycle latency).
    - Multiple hits cannot occur.
    - Miss with lookup pending: go to REFILL and pulse axi_arvalid_o the same cycle.
  - REFILL: write each beat to the victim way at line base + beat index (beats start at word 0). On rvalid&&rlast, write the tag with valid=1 and the error bit=OR of all beat rresp!=0, then go to RELOOKUP.
  - RELOOKUP: re-read the registered address for one cycle, then go to LOOKUP. The lookup is still pending, so it now hits.
- req_accept_o = (state==LOOKUP) && no miss being resolved this cycle.
  - Flush or invalidate is accepted only via req_accept_o.
  - Priority: miss > invalidate > flush > read. A concurrent req_rd_i is accepted but dropped by the flush.
- axi_arvalid_o holds until axi_arready_i. Address = {lookup_pc[31:OFS_W], zeros}.
- Victim selection:
  - First way (lowest index) with valid=0 in the set.
  - Otherwise the victim pointer, which increments mod NUM_WAYS after every completed refill that used it.
  - NUM_WAYS=1 forces way 0.
- req_error_o = error bit of the hitting line, qualified by req_valid_o. An errored line stays resident until flushed or invalidated.
- Counters:
  - stat_hit_o increments on each req_valid_o.
  - stat_miss_o increments on each AR handshake.
  - Both saturate at 32'hFFFF_FFFF and clear only on reset.
- Reset mid-refill: state returns to FLUSH. Remaining R beats are absorbed (rready=1) and ignored until the FLUSH sweep ends. The AXI slave must also be reset.

Test Plan:
- Release reset with no requests -> req_accept_o=0 for NUM_SETS cycles, then 1; no AR issued.
- Cold fetch 0x0000_1004 (defaults) -> one AR to 0x0000_1000, arlen=7. Return 8 beats 0x100..0x107 -> req_valid_o with inst 0x101 two cycles after rlast. Refetch 0x1004 -> hit in 1 cycle, stat_hit=2, stat_miss=1.
- Fetch 0x1000, 0x1800, 0x2000 (same set 0, tags differ) -> ways 0,1 filled, third evicts way 0. Refetch 0x1800 hits; refetch 0x1000 misses.
- Refill 0x3000 with rresp=2'b10 on beat 3 -> req_valid_o=1 and req_error_o=1 for any word of that line. Invalidate 0x3000 -> next fetch re-misses.
- Hold axi_arready_i low for 5 cycles -> axi_arvalid_o stable with constant address, no duplicate AR.
- Assert req_flush_i during a hit stream -> accepted, FLUSH lasts NUM_SETS cycles, all previously hit addresses miss afterwards.

Source files
------------

// File: rtl/icache_nway_if.sv
// Fetch-side, AXI read-side and statistics signals of icache_nway.
// The cache takes the slave view; the fetch stage / fabric / bench take the master view.
interface icache_nway_if;
  // Fetch side: a request is taken on any cycle where req_accept_o is high.
  // AXI AR follows valid/ready: axi_arvalid_o holds with a stable address until axi_arready_i.
  // AXI R is always accepted (axi_rready_o tied high).
  logic        req_rd_i;
  logic        req_flush_i;
  logic        req_invalidate_i;
  logic [31:0] req_pc_i;
  logic        req_accept_o;
  logic        req_valid_o;
  logic        req_error_o;
  logic [31:0] req_inst_o;

  logic        axi_arvalid_o;
  logic [31:0] axi_araddr_o;
  logic [3:0]  axi_arid_o;
  logic [7:0]  axi_arlen_o;
  logic [1:0]  axi_arburst_o;
  logic [2:0]  axi_arsize_o;
  logic        axi_arready_i;
  logic        axi_rvalid_i;
  logic [31:0] axi_rdata_i;
  logic [1:0]  axi_rresp_i;
  logic        axi_rlast_i;
  logic        axi_rready_o;

  logic [31:0] stat_hit_o;
  logic [31:0] stat_miss_o;
  logic [1:0]  dbg_state;

  modport slave (
    input  req_rd_i, req_flush_i, req_invalidate_i, req_pc_i,
    output req_accept_o, req_valid_o, req_error_o, req_inst_o,
    output axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arburst_o, axi_arsize_o,
    input  axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i,
    output axi_rready_o,
    output stat_hit_o, stat_miss_o, dbg_state
  );

  modport master (
    output req_rd_i, req_flush_i, req_invalidate_i, req_pc_i,
    input  req_accept_o, req_valid_o, req_error_o, req_inst_o,
    input  axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arburst_o, axi_arsize_o,
    output axi_arready_i, axi_rvalid_i, axi_rdata_i, axi_rresp_i, axi_rlast_i,
    input  axi_rready_o,
    input  stat_hit_o, stat_miss_o, dbg_state
  );
endinterface

// File: rtl/icache_nway.sv
// Parametrised set-associative instruction cache with AXI line refill,
// invalid-first / round-robin replacement, per-line refill error and hit/miss counters.
module icache_nway #(
  parameter int AXI_ID     = 4,
  parameter int NUM_WAYS   = 2,
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  icache_nway_if.slave bus
);
  localparam int OFS_W  = $clog2(LINE_WORDS) + 2;
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - SET_W - OFS_W;
  localparam int BEAT_W = $clog2(LINE_WORDS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int DIDX_W = SET_W + BEAT_W;

  typedef enum logic [1:0] {
    ST_FLUSH    = 2'd0,
    ST_LOOKUP   = 2'd1,
    ST_REFILL   = 2'd2,
    ST_RELOOKUP = 2'd3
  } state_t;

  state_t            state;
  logic [SET_W-1:0]  flush_ptr;
  logic              flush_single;
  logic [WAY_W-1:0]  victim_ptr;
  logic [WAY_W-1:0]  refill_way;
  logic              refill_from_ptr;
  logic [31:0]       lookup_pc;
  logic              pending;
  logic [BEAT_W-1:0] beat_cnt;
  logic              refill_err;
  logic              arvalid;
  logic [31:0]       araddr;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  logic [NUM_WAYS-1:0] way_valid;
  logic [NUM_WAYS-1:0] way_err;
  logic [NUM_WAYS-1:0] way_hit;
  logic [31:0]         way_data [NUM_WAYS];

  logic [31:0]       rd_pc;
  logic [SET_W-1:0]  rd_set;
  logic [SET_W-1:0]  lk_set;
  logic [DIDX_W-1:0] rd_didx;
  logic [DIDX_W-1:0] wr_didx;
  logic              beat;
  logic              tag_we_flush;
  logic              tag_we_fill;
  logic              data_we;
  logic [TAG_W+1:0]  fill_tag_word;
  logic              hit_any;
  logic              hit_err;
  logic [31:0]       hit_data;
  logic              lookup_hit;
  logic              miss;
  logic              accept;
  logic [WAY_W-1:0]  victim_way;
  logic              victim_from_ptr;
  logic              unused_bits;

  // RAMs are read from the live request in LOOKUP, otherwise from the held address.
  assign rd_pc   = (state == ST_LOOKUP) ? bus.req_pc_i : lookup_pc;
  assign rd_set  = rd_pc[OFS_W +: SET_W];
  assign rd_didx = rd_pc[2 +: DIDX_W];
  assign lk_set  = lookup_pc[OFS_W +: SET_W];
  assign wr_didx = {lk_set, beat_cnt};

  // R beats count only once the AR has been handed off.
  assign beat          = (state == ST_REFILL) && !arvalid && bus.axi_rvalid_i;
  assign data_we       = beat;
  assign tag_we_fill   = beat && bus.axi_rlast_i;
  assign tag_we_flush  = (state == ST_FLUSH);
  assign fill_tag_word = {1'b1, refill_err | (bus.axi_rresp_i != 2'b00), lookup_pc[31 -: TAG_W]};

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    logic [TAG_W+1:0] tag_mem  [NUM_SETS];
    logic [31:0]      data_mem [NUM_SETS*LINE_WORDS];
    logic [TAG_W+1:0] tag_q;
    logic [31:0]      data_q;
    logic             sel;

    assign sel = (refill_way == WAY_W'(w));

    always_ff @(posedge clk_i) begin
      if (tag_we_flush) tag_mem[flush_ptr] <= '0;
      else if (tag_we_fill && sel) tag_mem[lk_set] <= fill_tag_word;
      if (data_we && sel) data_mem[wr_didx] <= bus.axi_rdata_i;
      tag_q  <= tag_mem[rd_set];
      data_q <= data_mem[rd_didx];
    end

    assign way_valid[w] = tag_q[TAG_W+1];
    assign way_err[w]   = tag_q[TAG_W];
    assign way_hit[w]   = tag_q[TAG_W+1] && (tag_q[TAG_W-1:0] == lookup_pc[31 -: TAG_W]);
    assign way_data[w]  = data_q;
  end

  always_comb begin
    hit_data = '0;
    hit_err  = 1'b0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (way_hit[w]) begin
        hit_data = way_data[w];
        hit_err  = way_err[w];
      end
    end
  end

  // Lowest invalid way wins; a fully valid set falls back to the rotating pointer.
  always_comb begin
    victim_way      = victim_ptr;
    victim_from_ptr = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!way_valid[w]) begin
        victim_way      = WAY_W'(w);
        victim_from_ptr = 1'b0;
      end
    end
  end

  assign hit_any    = |way_hit;
  assign lookup_hit = (state == ST_LOOKUP) && pending && hit_any;
  assign miss       = (state == ST_LOOKUP) && pending && !hit_any;
  assign accept     = (state == ST_LOOKUP) && !miss;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= ST_FLUSH;
      flush_ptr       <= '0;
      flush_single    <= 1'b0;
      victim_ptr      <= '0;
      refill_way      <= '0;
      refill_from_ptr <= 1'b0;
      lookup_pc       <= '0;
      pending         <= 1'b0;
      beat_cnt        <= '0;
      refill_err      <= 1'b0;
      arvalid         <= 1'b0;
      araddr          <= '0;
    end else begin
      case (state)
        ST_FLUSH: begin
          flush_ptr <= flush_ptr + SET_W'(1);
          if (flush_single || (flush_ptr == SET_W'(NUM_SETS - 1))) begin
            state        <= ST_LOOKUP;
            flush_single <= 1'b0;
          end
        end
        ST_LOOKUP: begin
          if (miss) begin
            state           <= ST_REFILL;
            arvalid         <= 1'b1;
            araddr          <= {lookup_pc[31:OFS_W], {OFS_W{1'b0}}};
            beat_cnt        <= '0;
            refill_err      <= 1'b0;
            refill_way      <= victim_way;
            refill_from_ptr <= victim_from_ptr;
          end else if (bus.req_invalidate_i) begin
            state        <= ST_FLUSH;
            flush_ptr    <= bus.req_pc_i[OFS_W +: SET_W];
            flush_single <= 1'b1;
            pending      <= 1'b0;
          end else if (bus.req_flush_i) begin
            state        <= ST_FLUSH;
            flush_ptr    <= '0;
            flush_single <= 1'b0;
            pending      <= 1'b0;
          end else begin
            pending   <= bus.req_rd_i;
            lookup_pc <= bus.req_pc_i;
          end
        end
        ST_REFILL: begin
          if (arvalid && bus.axi_arready_i) arvalid <= 1'b0;
          if (beat) begin
            beat_cnt   <= beat_cnt + BEAT_W'(1);
            refill_err <= refill_err | (bus.axi_rresp_i != 2'b00);
            if (bus.axi_rlast_i) begin
              state <= ST_RELOOKUP;
              if (refill_from_ptr)
                victim_ptr <= (NUM_WAYS == 1) ? '0 : victim_ptr + WAY_W'(1);
            end
          end
        end
        default: state <= ST_LOOKUP;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (lookup_hit && (hit_cnt != 32'hFFFF_FFFF)) hit_cnt <= hit_cnt + 32'd1;
      if (arvalid && bus.axi_arready_i && (miss_cnt != 32'hFFFF_FFFF)) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.req_accept_o  = accept;
  assign bus.req_valid_o   = lookup_hit;
  assign bus.req_error_o   = lookup_hit & hit_err;
  assign bus.req_inst_o    = lookup_hit ? hit_data : 32'd0;
  assign bus.axi_arvalid_o = arvalid;
  assign bus.axi_araddr_o  = araddr;
  assign bus.axi_arid_o    = 4'(AXI_ID);
  assign bus.axi_arlen_o   = 8'(LINE_WORDS - 1);
  assign bus.axi_arburst_o = 2'd1;
  assign bus.axi_arsize_o  = 3'd2;
  assign bus.axi_rready_o  = 1'b1;
  assign bus.stat_hit_o    = hit_cnt;
  assign bus.stat_miss_o   = miss_cnt;
  assign bus.dbg_state     = state;

  assign unused_bits = ^{rd_pc[1:0], rd_pc[31:SET_W+OFS_W]};
endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (defaults: 2 ways, 64 sets, 8-word lines).
// Set index = pc[10:5], tag = pc[31:11]; all expectations below are hand-computed.
module tb_icache_nway;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests_run = 0;
  int tests_failed = 0;
  int ar_count = 0;

  icache_nway_if bus();

  icache_nway #(.AXI_ID(4), .NUM_WAYS(2), .NUM_SETS(64), .LINE_WORDS(8)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.axi_arvalid_o && bus.axi_arready_i) ar_count <= ar_count + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic wait_accept();
    int n = 0;
    while (bus.req_accept_o !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (bus.req_accept_o !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL accept_timeout: req_accept_o=%b, required 1", bus.req_accept_o);
    end
  endtask

  task automatic do_fetch(input logic [31:0] pc, output logic v, output logic [31:0] inst, output logic e);
    wait_accept();
    bus.req_rd_i = 1'b1; bus.req_pc_i = pc;
    @(negedge clk);
    bus.req_rd_i = 1'b0;
    v = bus.req_valid_o; inst = bus.req_inst_o; e = bus.req_error_o;
  endtask

  task automatic do_ctl(input logic fl, input logic inv, input logic [31:0] pc);
    wait_accept();
    bus.req_flush_i = fl; bus.req_invalidate_i = inv; bus.req_pc_i = pc;
    @(negedge clk);
    bus.req_flush_i = 1'b0; bus.req_invalidate_i = 1'b0;
  endtask

  // AXI slave: take one AR (optionally stalled), return 8 beats base+i.
  task automatic serve(input logic [31:0] base, input int err_beat, input int stall,
                       output logic [31:0] addr, output logic [7:0] len, output logic stable);
    int n = 0;
    stable = 1'b1; addr = '0; len = '0;
    while (bus.axi_arvalid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (bus.axi_arvalid_o !== 1'b1) begin
      tests_run++; tests_failed++;
      $display("FAIL ar_timeout: axi_arvalid_o=%b, required 1", bus.axi_arvalid_o);
      return;
    end
    addr = bus.axi_araddr_o; len = bus.axi_arlen_o;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (bus.axi_arvalid_o !== 1'b1 || bus.axi_araddr_o !== addr) stable = 1'b0;
    end
    bus.axi_arready_i = 1'b1;
    @(negedge clk);
    bus.axi_arready_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.axi_rvalid_i = 1'b1; bus.axi_rdata_i = base + 32'(i);
      bus.axi_rresp_i = (i == err_beat) ? 2'b10 : 2'b00; bus.axi_rlast_i = (i == 7);
      @(negedge clk);
    end
    bus.axi_rvalid_i = 1'b0; bus.axi_rlast_i = 1'b0; bus.axi_rresp_i = 2'b00; bus.axi_rdata_i = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++; if (bus.req_accept_o !== 1'b0) begin tests_failed++; $display("FAIL rst_accept: got %b required 0", bus.req_accept_o); end
    tests_run++; if (bus.req_valid_o !== 1'b0 || bus.axi_arvalid_o !== 1'b0) begin tests_failed++; $display("FAIL rst_valids: got valid=%b arvalid=%b required 0 0", bus.req_valid_o, bus.axi_arvalid_o); end
    tests_run++; if ({bus.axi_rready_o, bus.axi_arid_o, bus.axi_arlen_o, bus.axi_arburst_o, bus.axi_arsize_o} !== {1'b1, 4'd4, 8'd7, 2'd1, 3'd2}) begin tests_failed++; $display("FAIL rst_axi_const: got rready=%b id=%h len=%h burst=%h size=%h required 1 4 07 1 2", bus.axi_rready_o, bus.axi_arid_o, bus.axi_arlen_o, bus.axi_arburst_o, bus.axi_arsize_o); end
    tests_run++; if (bus.stat_hit_o !== 32'd0 || bus.stat_miss_o !== 32'd0) begin tests_failed++; $display("FAIL rst_stats: got hit=%0d miss=%0d required 0 0", bus.stat_hit_o, bus.stat_miss_o); end
    tests_run++; if (bus.dbg_state !== 2'd0) begin tests_failed++; $display("FAIL rst_state: got %0d required 0", bus.dbg_state); end
    rst_n = 1'b1;
    while (bus.req_accept_o !== 1'b1 && n < 500) begin n++; @(negedge clk); end
    tests_run++; if (n != 64) begin tests_failed++; $display("FAIL rst_sweep_len: got %0d required 64", n); end
    tests_run++; if (bus.dbg_state !== 2'd1) begin tests_failed++; $display("FAIL rst_lookup_state: got %0d required 1", bus.dbg_state); end
    tests_run++; if (ar_count != 0) begin tests_failed++; $display("FAIL rst_no_ar: got %0d required 0", ar_count); end
  endtask

  task automatic test_cold();
    logic v, e, st; logic [31:0] inst, addr; logic [7:0] len; int a0;
    do_fetch(32'h0000_1004, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL cold_miss: valid=%b required 0", v); end
    a0 = ar_count;
    serve(32'h100, -1, 0, addr, len, st);
    tests_run++; if (addr !== 32'h0000_1000 || len !== 8'd7) begin tests_failed++; $display("FAIL cold_ar: addr=%h len=%0d required 00001000 7", addr, len); end
    tests_run++; if (bus.req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL cold_relookup: valid=%b required 0", bus.req_valid_o); end
    @(negedge clk);
    tests_run++; if (bus.req_valid_o !== 1'b1 || bus.req_inst_o !== 32'h101 || bus.req_error_o !== 1'b0) begin tests_failed++; $display("FAIL cold_fill_hit: valid=%b inst=%h err=%b required 1 00000101 0", bus.req_valid_o, bus.req_inst_o, bus.req_error_o); end
    do_fetch(32'h0000_1004, v, inst, e);
    tests_run++; if (v !== 1'b1 || inst !== 32'h101) begin tests_failed++; $display("FAIL cold_refetch: valid=%b inst=%h required 1 00000101", v, inst); end
    @(negedge clk);
    tests_run++; if (bus.stat_hit_o !== 32'd2 || bus.stat_miss_o !== 32'd1 || ar_count - a0 != 1) begin tests_failed++; $display("FAIL cold_stats: hit=%0d miss=%0d ars=%0d required 2 1 1", bus.stat_hit_o, bus.stat_miss_o, ar_count - a0); end
  endtask

  task automatic test_assoc();
    logic v, e, st; logic [31:0] inst, addr; logic [7:0] len;
    do_fetch(32'h0000_1000, v, inst, e);
    tests_run++; if (v !== 1'b1 || inst !== 32'h100) begin tests_failed++; $display("FAIL assoc_hit_1000: valid=%b inst=%h required 1 00000100", v, inst); end
    do_fetch(32'h0000_1800, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL assoc_miss_1800: valid=%b required 0", v); end
    serve(32'h200, -1, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (addr !== 32'h1800 || bus.req_inst_o !== 32'h200) begin tests_failed++; $display("FAIL assoc_fill_1800: addr=%h inst=%h required 00001800 00000200", addr, bus.req_inst_o); end
    do_fetch(32'h0000_2000, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL assoc_miss_2000: valid=%b required 0", v); end
    serve(32'h300, -1, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (addr !== 32'h2000 || bus.req_inst_o !== 32'h300) begin tests_failed++; $display("FAIL assoc_fill_2000: addr=%h inst=%h required 00002000 00000300", addr, bus.req_inst_o); end
    do_fetch(32'h0000_1800, v, inst, e);
    tests_run++; if (v !== 1'b1 || inst !== 32'h200) begin tests_failed++; $display("FAIL assoc_keep_1800: valid=%b inst=%h required 1 00000200", v, inst); end
    do_fetch(32'h0000_1000, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL assoc_evicted_1000: valid=%b required 0", v); end
    serve(32'h400, -1, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (bus.req_valid_o !== 1'b1 || bus.req_inst_o !== 32'h400) begin tests_failed++; $display("FAIL assoc_fill_1000: valid=%b inst=%h required 1 00000400", bus.req_valid_o, bus.req_inst_o); end
    do_fetch(32'h0000_2000, v, inst, e);
    tests_run++; if (v !== 1'b1 || inst !== 32'h300) begin tests_failed++; $display("FAIL assoc_rr_2000: valid=%b inst=%h required 1 00000300", v, inst); end
    @(negedge clk);
    tests_run++; if (bus.stat_hit_o !== 32'd8 || bus.stat_miss_o !== 32'd4) begin tests_failed++; $display("FAIL assoc_stats: hit=%0d miss=%0d required 8 4", bus.stat_hit_o, bus.stat_miss_o); end
  endtask

  task automatic test_error();
    logic v, e, st; logic [31:0] inst, addr; logic [7:0] len;
    do_fetch(32'h0000_3000, v, inst, e);
    serve(32'h500, 3, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (bus.req_valid_o !== 1'b1 || bus.req_error_o !== 1'b1 || bus.req_inst_o !== 32'h500) begin tests_failed++; $display("FAIL err_fill: valid=%b err=%b inst=%h required 1 1 00000500", bus.req_valid_o, bus.req_error_o, bus.req_inst_o); end
    do_fetch(32'h0000_301C, v, inst, e);
    tests_run++; if (v !== 1'b1 || e !== 1'b1 || inst !== 32'h507) begin tests_failed++; $display("FAIL err_other_word: valid=%b err=%b inst=%h required 1 1 00000507", v, e, inst); end
    do_fetch(32'h0000_1000, v, inst, e);
    tests_run++; if (v !== 1'b1 || e !== 1'b0 || inst !== 32'h400) begin tests_failed++; $display("FAIL err_neighbour: valid=%b err=%b inst=%h required 1 0 00000400", v, e, inst); end
    do_ctl(1'b0, 1'b1, 32'h0000_3000);
    do_fetch(32'h0000_3000, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL inv_remiss: valid=%b required 0", v); end
    serve(32'h600, -1, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (addr !== 32'h3000 || bus.req_error_o !== 1'b0 || bus.req_inst_o !== 32'h600) begin tests_failed++; $display("FAIL inv_refill: addr=%h err=%b inst=%h required 00003000 0 00000600", addr, bus.req_error_o, bus.req_inst_o); end
    do_fetch(32'h0000_1000, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL inv_all_ways: valid=%b required 0", v); end
    serve(32'h400, -1, 0, addr, len, st);
    @(negedge clk);
  endtask

  task automatic test_ar_stall();
    logic v, e, st; logic [31:0] inst, addr; logic [7:0] len; int a0;
    do_fetch(32'h0000_4040, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL stall_miss: valid=%b required 0", v); end
    a0 = ar_count;
    serve(32'h700, -1, 5, addr, len, st);
    tests_run++; if (st !== 1'b1 || addr !== 32'h4040) begin tests_failed++; $display("FAIL stall_stable: stable=%b addr=%h required 1 00004040", st, addr); end
    tests_run++; if (ar_count - a0 != 1) begin tests_failed++; $display("FAIL stall_single_ar: got %0d ARs required 1", ar_count - a0); end
    @(negedge clk);
    tests_run++; if (bus.req_valid_o !== 1'b1 || bus.req_inst_o !== 32'h700) begin tests_failed++; $display("FAIL stall_fill: valid=%b inst=%h required 1 00000700", bus.req_valid_o, bus.req_inst_o); end
  endtask

  task automatic test_back_to_back();
    logic v, e; logic [31:0] inst;
    for (int i = 1; i < 8; i++) begin
      do_fetch(32'h0000_4040 + 32'(4 * i), v, inst, e);
      tests_run++; if (v !== 1'b1 || inst !== 32'h700 + 32'(i)) begin tests_failed++; $display("FAIL b2b_word%0d: valid=%b inst=%h required 1 %h", i, v, inst, 32'h700 + 32'(i)); end
    end
  endtask

  task automatic test_flush();
    logic v, e, st; logic [31:0] inst, addr; logic [7:0] len; int n = 0;
    do_fetch(32'h0000_4040, v, inst, e);
    tests_run++; if (v !== 1'b1) begin tests_failed++; $display("FAIL flush_pre_hit: valid=%b required 1", v); end
    bus.req_flush_i = 1'b1; bus.req_rd_i = 1'b1; bus.req_pc_i = 32'h0000_4044;
    @(negedge clk);
    bus.req_flush_i = 1'b0; bus.req_rd_i = 1'b0;
    tests_run++; if (bus.req_valid_o !== 1'b0) begin tests_failed++; $display("FAIL flush_drops_read: valid=%b required 0", bus.req_valid_o); end
    while (bus.req_accept_o !== 1'b1 && n < 500) begin n++; @(negedge clk); end
    tests_run++; if (n != 64) begin tests_failed++; $display("FAIL flush_len: got %0d required 64", n); end
    do_fetch(32'h0000_4040, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL flush_miss_4040: valid=%b required 0", v); end
    serve(32'h800, -1, 0, addr, len, st);
    @(negedge clk);
    do_fetch(32'h0000_3000, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL flush_miss_3000: valid=%b required 0", v); end
    serve(32'h900, -1, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (bus.req_valid_o !== 1'b1 || bus.req_inst_o !== 32'h900) begin tests_failed++; $display("FAIL flush_refill: valid=%b inst=%h required 1 00000900", bus.req_valid_o, bus.req_inst_o); end
  endtask

  task automatic test_reset_mid_refill();
    logic v, e, st; logic [31:0] inst, addr; logic [7:0] len; int n = 0;
    do_fetch(32'h0000_5000, v, inst, e);
    while (bus.axi_arvalid_o !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    bus.axi_arready_i = 1'b1;
    @(negedge clk);
    bus.axi_arready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.axi_rvalid_i = 1'b1; bus.axi_rdata_i = 32'hB00 + 32'(i); bus.axi_rlast_i = 1'b0;
      @(negedge clk);
    end
    rst_n = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.dbg_state !== 2'd0 || bus.req_accept_o !== 1'b0 || bus.axi_arvalid_o !== 1'b0) begin tests_failed++; $display("FAIL midrst_state: state=%0d accept=%b arvalid=%b required 0 0 0", bus.dbg_state, bus.req_accept_o, bus.axi_arvalid_o); end
    tests_run++; if (bus.stat_hit_o !== 32'd0 || bus.stat_miss_o !== 32'd0) begin tests_failed++; $display("FAIL midrst_stats: hit=%0d miss=%0d required 0 0", bus.stat_hit_o, bus.stat_miss_o); end
    rst_n = 1'b1;
    for (int i = 3; i < 8; i++) begin
      bus.axi_rvalid_i = 1'b1; bus.axi_rdata_i = 32'hB00 + 32'(i); bus.axi_rlast_i = (i == 7);
      @(negedge clk);
    end
    bus.axi_rvalid_i = 1'b0; bus.axi_rlast_i = 1'b0; bus.axi_rdata_i = '0;
    do_fetch(32'h0000_5000, v, inst, e);
    tests_run++; if (v !== 1'b0) begin tests_failed++; $display("FAIL midrst_discarded: valid=%b required 0", v); end
    serve(32'hA00, -1, 0, addr, len, st);
    @(negedge clk);
    tests_run++; if (addr !== 32'h5000 || bus.req_valid_o !== 1'b1 || bus.req_inst_o !== 32'hA00) begin tests_failed++; $display("FAIL midrst_refill: addr=%h valid=%b inst=%h required 00005000 1 00000A00", addr, bus.req_valid_o, bus.req_inst_o); end
  endtask

  initial begin
    bus.req_rd_i = 1'b0; bus.req_flush_i = 1'b0; bus.req_invalidate_i = 1'b0; bus.req_pc_i = '0;
    bus.axi_arready_i = 1'b0; bus.axi_rvalid_i = 1'b0; bus.axi_rdata_i = '0;
    bus.axi_rresp_i = 2'b00; bus.axi_rlast_i = 1'b0;
    test_reset();
    test_cold();
    test_assoc();
    test_error();
    test_ar_stall();
    test_back_to_back();
    test_flush();
    test_reset_mid_refill();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
